// File: rtl/rv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rv32_mem_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch
// port (if_*) and the load/store port (d_*). The data port has fixed
// priority. A starvation counter forces fetch to win after STARVE_LIMIT
// consecutive denied fetch cycles. Read responses come back in order, and
// a small owner-tag FIFO steers each one to the port that issued it.
//
// Parameters
//   STARVE_LIMIT     denied fetch cycles before fetch is forced (1..15)
//   MAX_OUTSTANDING  read responses in flight (power of two, 1..8)
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_req/if_addr                 fetch read request
//   if_gnt/if_stall                fetch accepted / fetch stalled this cycle
//   if_rvalid/if_rdata             fetch read response
//   d_req/d_we/d_addr/d_wdata/d_wstrb   data request (read or write)
//   d_gnt/d_stall                  data accepted / data stalled this cycle
//   d_rvalid/d_rdata               load response
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb   request to memory
//   mem_gnt                        memory accepts the request this cycle
//   mem_rvalid/mem_rdata           in-order read response from memory
//   err                            sticky: response with no read outstanding
// ---------------------------------------------------------------------------
module rv32_mem_arbiter #(
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  // memory side
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  // status
  output logic        err
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [3:0]       STARVE_MAX = 4'(STARVE_LIMIT);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic             tag_reg [MAX_OUTSTANDING];  // 0 = fetch, 1 = data
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [3:0]       starve_reg, starve_next;
  logic             err_reg, err_next;

  // -------------------------------------------------------------------------
  // FIFO status and eligibility
  // -------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic head_tag;
  logic pop;
  logic read_ok;
  logic if_elig;
  logic d_elig;
  logic force_if;
  logic if_win;
  logic d_win;
  logic push;
  logic push_tag;

  assign fifo_full  = (count_reg == CNT_FULL);
  assign fifo_empty = (count_reg == '0);
  assign head_tag   = tag_reg[rd_ptr_reg];

  // A response only pops when something is outstanding; a stray response
  // is flagged through err instead.
  assign pop = mem_rvalid & ~fifo_empty;

  // A pop in the same cycle frees a slot, so a full FIFO does not block a
  // read that is accepted alongside a returning response.
  assign read_ok = ~fifo_full | pop;

  assign if_elig  = if_req & read_ok;
  assign d_elig   = d_req & (d_we | read_ok);
  assign force_if = (starve_reg == STARVE_MAX);

  // Data has priority unless the starvation override is active.
  assign if_win = if_elig & (force_if | ~d_elig);
  assign d_win  = d_elig & ~if_win;

  assign if_gnt   = if_win & mem_gnt;
  assign d_gnt    = d_win & mem_gnt;
  assign if_stall = if_req & ~if_gnt;
  assign d_stall  = d_req & ~d_gnt;

  // Only accepted reads take a tag; writes never produce a response.
  assign push     = if_gnt | (d_gnt & ~d_we);
  assign push_tag = d_gnt;

  // -------------------------------------------------------------------------
  // Memory request mux
  // -------------------------------------------------------------------------
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    if (if_win) begin
      mem_req  = 1'b1;
      mem_addr = if_addr;
    end else if (d_win) begin
      mem_req   = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wstrb = d_we ? d_wstrb : 4'h0;
    end
  end

  // -------------------------------------------------------------------------
  // Response routing (combinational, zero added latency)
  // -------------------------------------------------------------------------
  always_comb begin
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = 32'h0;
    d_rdata   = 32'h0;
    if (pop) begin
      if (head_tag) begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
    end
  end

  assign err = err_reg;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    starve_next = starve_reg;
    err_next    = err_reg | (mem_rvalid & fifo_empty);

    if (push) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
    end

    // Simultaneous push and pop leave the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    // Counts consecutive denied fetch cycles; a dropped request or a grant
    // restarts the count.
    if (~if_req | if_gnt) begin
      starve_next = 4'h0;
    end else if (starve_reg != STARVE_MAX) begin
      starve_next = starve_reg + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      starve_reg <= 4'h0;
      err_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      starve_reg <= starve_next;
      err_reg    <= err_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_reg[i] <= 1'b0;
      end
    end else if (push) begin
      tag_reg[wr_ptr_reg] <= push_tag;
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for rv32_mem_arbiter (default parameters:
// STARVE_LIMIT = 4, MAX_OUTSTANDING = 2). Inputs change 1 time unit after
// a rising edge; outputs are checked 2 units later, well clear of the edge.
// ---------------------------------------------------------------------------
module tb_rv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rv32_mem_arbiter #(.STARVE_LIMIT(4), .MAX_OUTSTANDING(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_stall   (if_stall),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_wstrb    (d_wstrb),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_stall    (d_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .err        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req     = 1'b0;
    if_addr    = 32'h0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    d_addr     = 32'h0;
    d_wdata    = 32'h0;
    d_wstrb    = 4'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #3;
    total++; if ({if_gnt, if_rvalid, if_stall, d_gnt, d_rvalid, d_stall, mem_req, mem_we, mem_wstrb, err} !== 13'h0)
      $display("FAIL reset_ctrl got=%0h exp=0", {if_gnt, if_rvalid, if_stall, d_gnt, d_rvalid, d_stall, mem_req, mem_we, mem_wstrb, err}); else passed++;
    total++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0)
      $display("FAIL reset_data got=%0h exp=0", {mem_addr, mem_wdata, if_rdata, d_rdata}); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if ({mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid, err} !== 6'h0)
      $display("FAIL idle_after_reset got=%0h exp=0", {mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid, err}); else passed++;
    $display("[tb] test_reset done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_first_fetch();
    idle();
    if_req = 1'b1; if_addr = 32'h100; mem_gnt = 1'b1;
    #2;
    total++; if (if_gnt !== 1'b1) $display("FAIL first_if_gnt got=%0h exp=1", if_gnt); else passed++;
    total++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100})
      $display("FAIL first_mem_req got=%0h exp=%0h", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h100}); else passed++;
    total++; if (if_stall !== 1'b0) $display("FAIL first_if_stall got=%0h exp=0", if_stall); else passed++;
    tick();
    idle();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #2;
    total++; if ({if_rvalid, if_rdata} !== {1'b1, 32'hDEADBEEF})
      $display("FAIL first_if_resp got=%0h exp=%0h", {if_rvalid, if_rdata}, {1'b1, 32'hDEADBEEF}); else passed++;
    total++; if ({d_rvalid, d_rdata} !== 33'h0)
      $display("FAIL first_d_quiet got=%0h exp=0", {d_rvalid, d_rdata}); else passed++;
    tick();
    idle();
    $display("[tb] test_first_fetch done");
  endtask

  // -------------------------------------------------------------------------
  // Fetch and data read contend; memory answers each data read one cycle
  // later. After 4 denied cycles the fetch is forced through on cycle 5.
  task automatic test_starvation();
    for (int k = 1; k <= 5; k++) begin
      idle();
      if_req = 1'b1; if_addr = 32'h200;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
      mem_gnt = 1'b1;
      mem_rvalid = (k > 1);
      mem_rdata = 32'(32'h1000 + k);
      #2;
      if (k < 5) begin
        total++; if ({d_gnt, if_gnt, if_stall} !== 3'b101)
          $display("FAIL starve_cyc%0d_data_wins got=%0b exp=101", k, {d_gnt, if_gnt, if_stall}); else passed++;
        total++; if (mem_addr !== 32'h800)
          $display("FAIL starve_cyc%0d_addr got=%0h exp=800", k, mem_addr); else passed++;
      end else begin
        total++; if ({if_gnt, d_gnt, d_stall, if_stall} !== 4'b1010)
          $display("FAIL starve_forced_fetch got=%0b exp=1010", {if_gnt, d_gnt, d_stall, if_stall}); else passed++;
        total++; if (mem_addr !== 32'h200)
          $display("FAIL starve_forced_addr got=%0h exp=200", mem_addr); else passed++;
      end
      if (k > 1) begin
        total++; if ({d_rvalid, d_rdata, if_rvalid} !== {1'b1, 32'(32'h1000 + k), 1'b0})
          $display("FAIL starve_cyc%0d_resp got=%0h exp=%0h", k, {d_rvalid, d_rdata, if_rvalid}, {1'b1, 32'(32'h1000 + k), 1'b0}); else passed++;
      end
      tick();
    end
    idle();
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    #2;
    total++; if ({if_rvalid, if_rdata, d_rvalid} !== {1'b1, 32'h55, 1'b0})
      $display("FAIL starve_drain got=%0h exp=%0h", {if_rvalid, if_rdata, d_rvalid}, {1'b1, 32'h55, 1'b0}); else passed++;
    tick();
    idle();
    $display("[tb] test_starvation done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    idle();
    if_req = 1'b1; if_addr = 32'h300; mem_gnt = 1'b1;
    #2;
    total++; if (if_gnt !== 1'b1) $display("FAIL b2b_fetch_gnt got=%0h exp=1", if_gnt); else passed++;
    tick();
    idle();
    d_req = 1'b1; d_addr = 32'h900; mem_gnt = 1'b1;
    #2;
    total++; if ({d_gnt, mem_addr, mem_we} !== {1'b1, 32'h900, 1'b0})
      $display("FAIL b2b_data_gnt got=%0h exp=%0h", {d_gnt, mem_addr, mem_we}, {1'b1, 32'h900, 1'b0}); else passed++;
    tick();
    // FIFO now holds two tags: a third read must be held off.
    idle();
    if_req = 1'b1; if_addr = 32'h304; mem_gnt = 1'b1;
    #2;
    total++; if ({if_gnt, if_stall, mem_req, mem_addr} !== {1'b0, 1'b1, 1'b0, 32'h0})
      $display("FAIL b2b_full_blocks got=%0h exp=%0h", {if_gnt, if_stall, mem_req, mem_addr}, {1'b0, 1'b1, 1'b0, 32'h0}); else passed++;
    tick();
    $display("[tb] test_back_to_back issue done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_write_when_full();
    idle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D; d_wstrb = 4'b0011;
    mem_gnt = 1'b1;
    #2;
    total++; if ({d_gnt, mem_req, mem_we} !== 3'b111)
      $display("FAIL wr_full_gnt got=%0b exp=111", {d_gnt, mem_req, mem_we}); else passed++;
    total++; if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h40, 32'hCAFEF00D, 4'b0011})
      $display("FAIL wr_full_bus got=%0h exp=%0h", {mem_addr, mem_wdata, mem_wstrb}, {32'h40, 32'hCAFEF00D, 4'b0011}); else passed++;
    total++; if ({if_rvalid, d_rvalid} !== 2'b00)
      $display("FAIL wr_full_no_rvalid got=%0b exp=00", {if_rvalid, d_rvalid}); else passed++;
    tick();
    // The write must not have changed occupancy: still full.
    idle();
    if_req = 1'b1; if_addr = 32'h304; mem_gnt = 1'b1;
    #2;
    total++; if ({if_gnt, mem_req} !== 2'b00)
      $display("FAIL wr_full_still_full got=%0b exp=00", {if_gnt, mem_req}); else passed++;
    tick();
    $display("[tb] test_write_when_full done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_responses();
    // First response pops the fetch tag while a new fetch read is pushed.
    idle();
    if_req = 1'b1; if_addr = 32'h304; mem_gnt = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h11;
    #2;
    total++; if ({if_rvalid, if_rdata, d_rvalid, d_rdata} !== {1'b1, 32'h11, 1'b0, 32'h0})
      $display("FAIL resp1_fetch got=%0h exp=%0h", {if_rvalid, if_rdata, d_rvalid, d_rdata}, {1'b1, 32'h11, 1'b0, 32'h0}); else passed++;
    total++; if ({if_gnt, mem_addr} !== {1'b1, 32'h304})
      $display("FAIL resp1_push_with_pop got=%0h exp=%0h", {if_gnt, mem_addr}, {1'b1, 32'h304}); else passed++;
    tick();
    idle();
    mem_rvalid = 1'b1; mem_rdata = 32'h22;
    #2;
    total++; if ({d_rvalid, d_rdata, if_rvalid, if_rdata} !== {1'b1, 32'h22, 1'b0, 32'h0})
      $display("FAIL resp2_data got=%0h exp=%0h", {d_rvalid, d_rdata, if_rvalid, if_rdata}, {1'b1, 32'h22, 1'b0, 32'h0}); else passed++;
    tick();
    idle();
    mem_rvalid = 1'b1; mem_rdata = 32'h33;
    #2;
    total++; if ({if_rvalid, if_rdata, d_rvalid} !== {1'b1, 32'h33, 1'b0})
      $display("FAIL resp3_fetch got=%0h exp=%0h", {if_rvalid, if_rdata, d_rvalid}, {1'b1, 32'h33, 1'b0}); else passed++;
    tick();
    idle();
    $display("[tb] test_responses done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_mem_wait();
    for (int k = 1; k <= 5; k++) begin
      idle();
      if_req = 1'b1; if_addr = 32'h400; mem_gnt = 1'b0;
      #2;
      total++; if ({if_gnt, if_stall, mem_req, mem_addr} !== {1'b0, 1'b1, 1'b1, 32'h400})
        $display("FAIL wait_cyc%0d got=%0h exp=%0h", k, {if_gnt, if_stall, mem_req, mem_addr}, {1'b0, 1'b1, 1'b1, 32'h400}); else passed++;
      tick();
    end
    // Counter is saturated: fetch beats a competing data write.
    idle();
    if_req = 1'b1; if_addr = 32'h400; mem_gnt = 1'b1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h1234; d_wstrb = 4'hF;
    #2;
    total++; if ({if_gnt, d_gnt, d_stall, mem_we, mem_wstrb, mem_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h400})
      $display("FAIL wait_forced got=%0h exp=%0h", {if_gnt, d_gnt, d_stall, mem_we, mem_wstrb, mem_addr}, {1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h400}); else passed++;
    tick();
    idle();
    mem_rvalid = 1'b1; mem_rdata = 32'h66;
    #2;
    total++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h66})
      $display("FAIL wait_resp got=%0h exp=%0h", {if_rvalid, if_rdata}, {1'b1, 32'h66}); else passed++;
    tick();
    idle();
    $display("[tb] test_mem_wait done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_spurious();
    idle();
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    #2;
    total++; if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== 66'h0)
      $display("FAIL spur_no_rvalid got=%0h exp=0", {if_rvalid, d_rvalid, if_rdata, d_rdata}); else passed++;
    total++; if (err !== 1'b0) $display("FAIL spur_err_before_edge got=%0h exp=0", err); else passed++;
    tick();
    idle();
    #2;
    total++; if (err !== 1'b1) $display("FAIL spur_err_set got=%0h exp=1", err); else passed++;
    tick();
    #2;
    total++; if (err !== 1'b1) $display("FAIL spur_err_sticky got=%0h exp=1", err); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (err !== 1'b0) $display("FAIL spur_async_clear got=%0h exp=0", err); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if ({err, mem_req, if_rvalid, d_rvalid} !== 4'h0)
      $display("FAIL spur_after_release got=%0h exp=0", {err, mem_req, if_rvalid, d_rvalid}); else passed++;
    $display("[tb] test_spurious done");
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_first_fetch();
    test_starvation();
    test_back_to_back();
    test_write_when_full();
    test_responses();
    test_mem_wait();
    test_spurious();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
